// File: rtl/bm_pkg.sv
// Shared bus-matrix definitions: HTRANS/HRESP encodings and port index width.
package bm_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int PORT_IDX_WIDTH = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } pend_state_e;

endpackage

// File: rtl/ahb_bm_input_stage.sv
// Per-master input stage: holds an address phase the target port cannot take yet,
// tracks the data phase, and routes the owning slave's ready/response back.
//
// state   | meaning
// ST_IDLE | live master transfer presented to the decoder
// ST_HELD | captured transfer presented; master stalled until granted
module ahb_bm_input_stage
    import bm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int PROT_WIDTH = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [PROT_WIDTH-1:0] HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  sel_op,
    output logic [ADDR_WIDTH-1:0] addr_op,
    output logic [1:0]            trans_op,
    output logic                  write_op,
    output logic [2:0]            size_op,
    output logic [2:0]            burst_op,
    output logic [PROT_WIDTH-1:0] prot_op,
    output logic                  mastlock_op,
    output logic                  held_tran_op,
    input  logic                  active_op,
    input  logic                  readyout_op,
    input  logic                  resp_op
);

    pend_state_e state, state_nxt;
    logic        data_pend;
    logic        new_tran;
    logic        capture;

    logic                  hold_sel;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [1:0]            hold_trans;
    logic                  hold_write;
    logic [2:0]            hold_size;
    logic [2:0]            hold_burst;
    logic [PROT_WIDTH-1:0] hold_prot;
    logic                  hold_mastlock;

    assign new_tran = HSELS & HREADYS & HTRANSS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (new_tran && !active_op) begin
                    state_nxt = ST_HELD;
                    capture   = 1'b1;
                end
            end
            ST_HELD: begin
                if (active_op) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Holding registers only load on entry to ST_HELD, so they stay frozen while stalled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_sel      <= 1'b0;
            hold_addr     <= '0;
            hold_trans    <= HTRANS_IDLE;
            hold_write    <= 1'b0;
            hold_size     <= '0;
            hold_burst    <= '0;
            hold_prot     <= '0;
            hold_mastlock <= 1'b0;
        end else if (capture) begin
            hold_sel      <= HSELS;
            hold_addr     <= HADDRS;
            hold_trans    <= HTRANSS;
            hold_write    <= HWRITES;
            hold_size     <= HSIZES;
            hold_burst    <= HBURSTS;
            hold_prot     <= HPROTS;
            hold_mastlock <= HMASTLOCKS;
        end
    end

    // A fresh acceptance wins over completion of the previous data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_pend <= 1'b0;
        end else if (active_op && trans_op[1]) begin
            data_pend <= 1'b1;
        end else if (readyout_op) begin
            data_pend <= 1'b0;
        end
    end

    always_comb begin
        held_tran_op = (state == ST_HELD);
        if (held_tran_op) begin
            sel_op      = hold_sel;
            addr_op     = hold_addr;
            trans_op    = hold_trans;
            write_op    = hold_write;
            size_op     = hold_size;
            burst_op    = hold_burst;
            prot_op     = hold_prot;
            mastlock_op = hold_mastlock;
        end else begin
            sel_op      = HSELS;
            addr_op     = HADDRS;
            trans_op    = HTRANSS;
            write_op    = HWRITES;
            size_op     = HSIZES;
            burst_op    = HBURSTS;
            prot_op     = HPROTS;
            mastlock_op = HMASTLOCKS;
        end
    end

    assign HREADYOUTS = held_tran_op ? 1'b0 : (data_pend ? readyout_op : 1'b1);
    assign HRESPS     = data_pend ? resp_op : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// Directed bench for ahb_bm_input_stage with hand-computed expectations.
module tb_ahb_bm_input_stage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic        HRESPS;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic        mastlock_op;
    logic        held_tran_op;
    logic        active_op;
    logic        readyout_op;
    logic        resp_op;

    int errors = 0;
    int checks = 0;

    ahb_bm_input_stage #(.ADDR_WIDTH(32), .PROT_WIDTH(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
        .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
        .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op), .write_op(write_op),
        .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
        .mastlock_op(mastlock_op), .held_tran_op(held_tran_op),
        .active_op(active_op), .readyout_op(readyout_op), .resp_op(resp_op)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                         input logic wr, input logic rdy);
        HSELS   = sel;
        HADDRS  = addr;
        HTRANSS = trans;
        HWRITES = wr;
        HREADYS = rdy;
    endtask

    initial begin
        HRESETn = 1'b0;
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'h0; HMASTLOCKS = 1'b0;
        active_op = 1'b0; readyout_op = 1'b0; resp_op = 1'b0;
        repeat (2) tick();
        HRESETn = 1'b1;
        tick();

        // Post-reset state
        HADDRS = 32'h1234_5678; #1;
        chk("rst_readyout", HREADYOUTS, 1);
        chk("rst_resp", HRESPS, 0);
        chk("rst_held", held_tran_op, 0);
        chk("rst_addr_live", addr_op, 32'h1234_5678);

        // Direct acceptance, data phase waits 0,0,1
        drive(1'b1, 32'h4000_0000, 2'b10, 1'b0, 1'b1);
        active_op = 1'b1; #1;
        chk("acc_addr", addr_op, 32'h4000_0000);
        chk("acc_ready_addrph", HREADYOUTS, 1);
        tick();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        active_op = 1'b0; readyout_op = 1'b0; #1;
        chk("acc_held", held_tran_op, 0);
        chk("acc_ready_w0", HREADYOUTS, 0);
        tick();
        chk("acc_ready_w1", HREADYOUTS, 0);
        readyout_op = 1'b1; #1;
        chk("acc_ready_done", HREADYOUTS, 1);
        tick();
        readyout_op = 1'b0; #1;
        chk("acc_dp_cleared", HREADYOUTS, 1);

        // Pipelined acceptance while previous data phase completes: data_pend stays set
        drive(1'b1, 32'h4000_0004, 2'b10, 1'b0, 1'b1);
        active_op = 1'b1;
        tick();
        drive(1'b1, 32'h4000_0008, 2'b11, 1'b0, 1'b1);
        readyout_op = 1'b1;
        tick();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        active_op = 1'b0; readyout_op = 1'b0; #1;
        chk("pipe_dp_kept", HREADYOUTS, 0);
        readyout_op = 1'b1;
        tick();
        readyout_op = 1'b0; #1;
        chk("pipe_dp_done", HREADYOUTS, 1);

        // Held transfer: 3 stalled cycles then grant
        drive(1'b1, 32'h2000_0010, 2'b10, 1'b1, 1'b1);
        HSIZES = 3'd2; HBURSTS = 3'd3; HPROTS = 4'hA;
        active_op = 1'b0;
        tick();
        drive(1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0);
        HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'h0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("held_ready", HREADYOUTS, 0);
            chk("held_addr", addr_op, 32'h2000_0010);
            chk("held_flag", held_tran_op, 1);
            tick();
        end
        chk("held_write", write_op, 1);
        chk("held_trans", trans_op, 2'b10);
        chk("held_sel", sel_op, 1);
        chk("held_size", size_op, 3'd2);
        chk("held_burst", burst_op, 3'd3);
        chk("held_prot", prot_op, 4'hA);
        active_op = 1'b1; #1;
        chk("held_grant_comb", held_tran_op, 1);
        tick();
        active_op = 1'b0; #1;
        chk("held_released", held_tran_op, 0);
        chk("held_addr_live", addr_op, 32'hDEAD_BEEF);
        chk("held_dataph_ready", HREADYOUTS, 0);

        // Overlap: data phase ends while new NONSEQ is refused
        drive(1'b1, 32'h3000_0000, 2'b10, 1'b0, 1'b1);
        readyout_op = 1'b1; #1;
        chk("ovl_ready_comb", HREADYOUTS, 1);
        tick();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        readyout_op = 1'b0; resp_op = 1'b1; #1;
        chk("ovl_ready", HREADYOUTS, 0);
        chk("ovl_held", held_tran_op, 1);
        chk("ovl_addr", addr_op, 32'h3000_0000);
        chk("ovl_resp_no_dp", HRESPS, 0);
        resp_op = 1'b0;
        active_op = 1'b1;
        tick();
        active_op = 1'b0; #1;

        // Two-cycle ERROR response
        resp_op = 1'b1; readyout_op = 1'b0; #1;
        chk("err_c1_resp", HRESPS, 1);
        chk("err_c1_ready", HREADYOUTS, 0);
        tick();
        readyout_op = 1'b1; #1;
        chk("err_c2_resp", HRESPS, 1);
        chk("err_c2_ready", HREADYOUTS, 1);
        tick();
        readyout_op = 1'b0; #1;
        chk("err_after_resp", HRESPS, 0);
        chk("err_after_ready", HREADYOUTS, 1);
        resp_op = 1'b0;

        // IDLE and BUSY with HSELS=1 never create state
        drive(1'b1, 32'h6000_0000, 2'b00, 1'b0, 1'b1); #1;
        chk("idle_sel", sel_op, 1);
        chk("idle_trans", trans_op, 2'b00);
        tick();
        chk("idle_held", held_tran_op, 0);
        chk("idle_ready", HREADYOUTS, 1);
        HTRANSS = 2'b01; active_op = 1'b1;
        tick();
        active_op = 1'b0; HTRANSS = 2'b00; #1;
        chk("busy_held", held_tran_op, 0);
        chk("busy_no_dp", HREADYOUTS, 1);

        // Locked transfer held, then reset mid-cycle discards it
        drive(1'b1, 32'h5000_0000, 2'b10, 1'b0, 1'b1);
        HMASTLOCKS = 1'b1;
        tick();
        drive(1'b0, 32'h0000_0040, 2'b00, 1'b0, 1'b0);
        HMASTLOCKS = 1'b0; #1;
        chk("lock_kept", mastlock_op, 1);
        chk("lock_held", held_tran_op, 1);
        #1 HRESETn = 1'b0; #1;
        chk("rstmid_ready", HREADYOUTS, 1);
        chk("rstmid_held", held_tran_op, 0);
        chk("rstmid_lock", mastlock_op, 0);
        chk("rstmid_addr", addr_op, 32'h0000_0040);
        tick();
        HRESETn = 1'b1;
        tick();
        chk("rst_no_replay", held_tran_op, 0);
        chk("rst_no_replay_rdy", HREADYOUTS, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_bm_input_stage.md
Name: ahb_bm_input_stage

Overview:
- Per-master input stage of the 5x7 AHB bus matrix; one instance sits on each slave-side (S) interface port, upstream of the per-slave output arbiters and output stages.
- Holds any address-phase transfer the targeted output port cannot accept immediately, and stalls the master with HREADYOUTS low until that port grants it.
- Tracks the data phase and returns slave HREADYOUT/HRESP to the master.
- Presents a muxed transfer (live or held) to the decoder; decoder output forms req_portN at each output arbiter.

Parameters:
ADDR_WIDTH, 32, address bus width
PROT_WIDTH, 4, HPROT width

Ports:
HCLK  input  1  AHB clock
HRESETn  input  1  asynchronous active-low reset
HSELS  input  1  master-side select
HADDRS  input  ADDR_WIDTH  master address
HTRANSS  input  2  master transfer type
HWRITES  input  1  master write
HSIZES  input  3  master size
HBURSTS  input  3  master burst
HPROTS  input  PROT_WIDTH  master protection
HMASTLOCKS  input  1  master lock
HREADYS  input  1  bus-wide HREADY seen by this port
HREADYOUTS  output  1  ready returned to master
HRESPS  output  1  response returned to master (0 OKAY, 1 ERROR)
sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op, mastlock_op  output  1/ADDR_WIDTH/2/1/3/3/PROT_WIDTH/1  transfer presented to decoder/arbiters
held_tran_op  output  1  presented transfer comes from holding register
active_op  input  1  an output stage grants this port and its slave HREADYM=1 this cycle (address phase accepted)
readyout_op  input  1  HREADYOUT of slave owning this port's data phase
resp_op  input  1  HRESP of that slave

Behaviour:
- Reset: HRESETn asynchronous, active-low; clock HCLK (rising edge). pend=0, data_pend=0, holding registers 0 (trans 2'b00). Outputs after reset: HREADYOUTS=1, HRESPS=0, held_tran_op=0, *_op equal live master inputs.
- new_tran = HSELS & HREADYS & HTRANSS[1].
- Mux: pend=1 -> *_op from holding registers, held_tran_op=1; else *_op = live inputs (combinational, zero latency).
- State pend: IDLE(0) -> HELD(1) at clock edge when new_tran & ~active_op; capture all address-phase signals. HELD -> IDLE when active_op=1. While HELD, holding registers frozen; master inputs ignored.
- State data_pend: set at edge when active_op & trans_op[1] (NONSEQ/SEQ accepted); cleared at edge when readyout_op=1 and no new acceptance that cycle; set-and-clear same cycle -> stays 1.
- HREADYOUTS = pend ? 0 : (data_pend ? readyout_op : 1).
- HRESPS = data_pend ? resp_op : 0. Two-cycle ERROR passes through unchanged (cycle 1: ready=0/ERROR; cycle 2: ready=1/ERROR).
- IDLE/BUSY transfers never set pend or data_pend; IDLE with HSELS=1 still drives sel_op=1 so the arbiter can hold its port.
- Simultaneous: data phase completing (readyout_op=1) and new_tran unaccepted in the same cycle -> data_pend clears, pend sets; master sees HREADYOUTS=0 next cycle.
- Locked: mastlock_op follows the mux; a held locked transfer keeps mastlock_op=1 until accepted.
- Reset mid-transfer: all state cleared immediately; no held transfer is replayed.

Decomposition:
- Shared package bm_pkg: HTRANS encodings (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11), HRESP OKAY/ERROR, port index width (3).
- No sub-module; the holding register and two state bits stay in one module.

Test Plan:
- Reset: assert HRESETn=0 mid-cycle -> HREADYOUTS=1, HRESPS=0, held_tran_op=0 immediately.
- Accepted directly: NONSEQ 0x4000_0000 with active_op=1 -> pend stays 0; data_pend=1; HREADYOUTS follows readyout_op (0,0,1 -> 0,0,1).
- Held: NONSEQ 0x2000_0010 write, active_op=0 for 3 cycles -> HREADYOUTS=0 for 3 cycles, addr_op=0x2000_0010, held_tran_op=1; active_op=1 -> pend clears next edge.
- Overlap: data phase ends (readyout_op=1) while NONSEQ unaccepted -> next cycle pend=1, data_pend=0, HREADYOUTS=0.
- Error: resp_op=1 with readyout_op 0 then 1 -> HRESPS=1 both cycles, HREADYOUTS 0 then 1.
- IDLE with HSELS=1 -> sel_op=1, trans_op=2'b00, pend and data_pend stay 0.
